// File: rtl/sram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_port_arbiter                                                |
// | Purpose : Round-robin sharing of a single-port SRAM macro between two      |
// |           requesters, with a bounded burst lock and 1-cycle read return.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_port_arbiter #(
   parameter int AW       = 10,
   parameter int DW       = 64,
   parameter int MAX_HOLD = 4
) (
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            m0_req,
   input  logic            m0_lock,
   input  logic [DW/8-1:0] m0_we,
   input  logic [AW-1:0]   m0_addr,
   input  logic [DW-1:0]   m0_wdata,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [DW-1:0]   m0_rdata,
   input  logic            m1_req,
   input  logic            m1_lock,
   input  logic [DW/8-1:0] m1_we,
   input  logic [AW-1:0]   m1_addr,
   input  logic [DW-1:0]   m1_wdata,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [DW-1:0]   m1_rdata,
   output logic            ram_en,
   output logic [DW/8-1:0] ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [DW-1:0]   ram_wdata,
   input  logic [DW-1:0]   ram_rdata
);

   localparam int              c_hw       = $clog2(MAX_HOLD + 1);
   localparam logic [c_hw-1:0] c_max_hold = c_hw'(MAX_HOLD);

   logic            r_last_owner;
   logic [c_hw-1:0] r_hold_cnt;
   logic            r_lock_prev;
   logic [1:0]      r_rd_pend;

   logic w_owner_req;
   logic w_locked;
   logic w_gnt0;
   logic w_gnt1;
   logic w_any_gnt;
   logic w_gnt_lock;

   assign w_owner_req = r_last_owner ? m1_req : m0_req;
   assign w_locked    = r_lock_prev & w_owner_req & (r_hold_cnt < c_max_hold);

   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (w_locked) begin
         w_gnt0 = ~r_last_owner;
         w_gnt1 = r_last_owner;
      end else if (m0_req && m1_req) begin
         w_gnt0 = r_last_owner;
         w_gnt1 = ~r_last_owner;
      end else begin
         w_gnt0 = m0_req;
         w_gnt1 = m1_req;
      end
   end

   assign w_any_gnt  = w_gnt0 | w_gnt1;
   assign w_gnt_lock = w_gnt1 ? m1_lock : m0_lock;

   // Idle macro pins are forced to zero rather than left following a port.
   always_comb begin
      ram_we    = '0;
      ram_addr  = '0;
      ram_wdata = '0;
      if (w_gnt0) begin
         ram_we    = m0_we;
         ram_addr  = m0_addr;
         ram_wdata = m0_wdata;
      end else if (w_gnt1) begin
         ram_we    = m1_we;
         ram_addr  = m1_addr;
         ram_wdata = m1_wdata;
      end
   end

   assign ram_en    = w_any_gnt;
   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m0_rvalid = r_rd_pend[0];
   assign m1_rvalid = r_rd_pend[1];
   assign m0_rdata  = ram_rdata;
   assign m1_rdata  = ram_rdata;

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         r_last_owner <= 1'b1;
         r_hold_cnt   <= '0;
         r_lock_prev  <= 1'b0;
         r_rd_pend    <= 2'b00;
      end else begin
         r_rd_pend <= {w_gnt1 & ~|m1_we, w_gnt0 & ~|m0_we};
         if (w_any_gnt) begin
            r_last_owner <= w_gnt1;
            r_lock_prev  <= w_gnt_lock;
            if (w_gnt1 == r_last_owner) begin
               if (r_hold_cnt != c_max_hold)
                  r_hold_cnt <= r_hold_cnt + c_hw'(1);
            end else begin
               r_hold_cnt <= c_hw'(1);
            end
         end else begin
            r_hold_cnt <= '0;
         end
      end
   end

endmodule
`default_nettype wire
